// File: rtl/pattern_scanner.sv
// pattern_scanner
//   Row-multiplexed LED matrix driver for the 5x5 guess/result grid produced by
//   updatePattern. A load strobe captures the packed grid into a shadow buffer.
//   The shadow is copied into the active buffer only while idle or on the edge
//   that wraps the last row back to row 0, so a displayed frame never mixes two
//   patterns.
//
//   Scan sequence per row: DWELL clocks lit, then BLANK clocks dark. When BLANK
//   is 0 the dark state is skipped. frame_done is high during the final cycle
//   of row ROWS-1.
//
//   Optional build macro PATTERN_SCANNER_BRIGHTNESS_EN adds the brightness
//   input. Brightness is sampled when each DWELL period begins. col_drv is then
//   driven only for the first (brightness+1)*DWELL/8 cycles of that period,
//   while row_sel stays asserted for the whole DWELL.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   pattern     packed grid, pattern[r] is row r
//   load        single-cycle capture strobe into the shadow buffer
//   enable      level, high = scanning, low = display off
//   brightness  [2:0] duty setting (only with PATTERN_SCANNER_BRIGHTNESS_EN)
//   row_sel     one-hot active-high row drive (registered)
//   col_drv     active-high column drive for the selected row (registered)
//   frame_done  one-cycle pulse on the last cycle of each frame (registered)

module pattern_scanner #(
    parameter int ROWS  = 5,
    parameter int COLS  = 5,
    parameter int DWELL = 1000,
    parameter int BLANK = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ROWS-1:0][COLS-1:0] pattern,
    input  logic                      load,
    input  logic                      enable,
`ifdef PATTERN_SCANNER_BRIGHTNESS_EN
    input  logic [2:0]                brightness,
`endif
    output logic [ROWS-1:0]           row_sel,
    output logic [COLS-1:0]           col_drv,
    output logic                      frame_done
);

    localparam int CMAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int LW   = CW + 1;

    localparam logic [CW-1:0] DW_LAST  = CW'(DWELL - 1);
    localparam logic [CW-1:0] BL_LAST  = CW'((BLANK > 0) ? BLANK - 1 : 0);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DWELL = 2'd1,
        S_BLANK = 2'd2
    } state_t;

    state_t                    state, state_n;
    logic [RW-1:0]             row, row_n;
    logic [CW-1:0]             cnt, cnt_n;
    logic [ROWS-1:0][COLS-1:0] shadow, shadow_n;
    logic [ROWS-1:0][COLS-1:0] active, active_n;
    logic                      pending, pending_n;
    logic                      wrap;
    logic                      swap;
    logic                      lit;
    logic [ROWS-1:0]           row_sel_n;
    logic [COLS-1:0]           col_drv_n;
    logic                      frame_done_n;

    // Next-state: scan sequencing
    always_comb begin
        state_n = state;
        row_n   = row;
        cnt_n   = cnt;
        wrap    = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable) begin
                    state_n = S_DWELL;
                    row_n   = '0;
                    cnt_n   = '0;
                end
            end
            S_DWELL: begin
                if (!enable) begin
                    state_n = S_IDLE;
                    row_n   = '0;
                    cnt_n   = '0;
                end else if (cnt == DW_LAST) begin
                    cnt_n = '0;
                    if (BLANK > 0) begin
                        state_n = S_BLANK;
                    end else if (row == ROW_LAST) begin
                        row_n = '0;
                        wrap  = 1'b1;
                    end else begin
                        row_n = row + 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_BLANK: begin
                if (!enable) begin
                    state_n = S_IDLE;
                    row_n   = '0;
                    cnt_n   = '0;
                end else if (cnt == BL_LAST) begin
                    cnt_n   = '0;
                    state_n = S_DWELL;
                    if (row == ROW_LAST) begin
                        row_n = '0;
                        wrap  = 1'b1;
                    end else begin
                        row_n = row + 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
                row_n   = '0;
                cnt_n   = '0;
            end
        endcase
    end

    // Next-state: double buffer. The swap reads the pre-edge shadow, so a load
    // on the swap edge lands in the shadow and stays pending for the next frame.
    always_comb begin
        swap      = pending && ((state == S_IDLE) || wrap);
        active_n  = swap ? shadow : active;
        shadow_n  = load ? pattern : shadow;
        pending_n = load ? 1'b1 : (swap ? 1'b0 : pending);
    end

`ifdef PATTERN_SCANNER_BRIGHTNESS_EN
    logic [2:0]    bright_r, bright_n;
    logic [LW-1:0] lit_lim;

    // Brightness is latched on the edge that starts a DWELL period, and that
    // value holds for the whole period.
    always_comb begin
        bright_n = bright_r;
        if (state_n == S_DWELL && cnt_n == '0) begin
            bright_n = brightness;
        end
        lit_lim = LW'((32'(bright_n) + 32'd1) * (DWELL / 8));
        lit     = (LW'(cnt_n) < lit_lim);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bright_r <= '0;
        end else begin
            bright_r <= bright_n;
        end
    end
`else
    always_comb begin
        lit = 1'b1;
    end
`endif

    // Output decode from next-state values, so outputs leave straight from flops
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            row_sel_n[r] = (state_n == S_DWELL) && (RW'(r) == row_n);
        end
        col_drv_n = '0;
        if (state_n == S_DWELL && lit) begin
            col_drv_n = active_n[row_n];
        end
        if (BLANK > 0) begin
            frame_done_n = (state_n == S_BLANK) && (row_n == ROW_LAST) && (cnt_n == BL_LAST);
        end else begin
            frame_done_n = (state_n == S_DWELL) && (row_n == ROW_LAST) && (cnt_n == DW_LAST);
        end
    end

    // Register stage: state, buffers and outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            row        <= '0;
            cnt        <= '0;
            shadow     <= '0;
            active     <= '0;
            pending    <= 1'b0;
            row_sel    <= '0;
            col_drv    <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            row        <= row_n;
            cnt        <= cnt_n;
            shadow     <= shadow_n;
            active     <= active_n;
            pending    <= pending_n;
            row_sel    <= row_sel_n;
            col_drv    <= col_drv_n;
            frame_done <= frame_done_n;
        end
    end

endmodule

// File: tb/tb_pattern_scanner.sv
// tb_pattern_scanner
//   Self-checking bench for pattern_scanner. It uses directed scenarios, then
//   randomized load, enable and brightness activity. Expected outputs come from
//   a frame-position model: the current cycle's offset in the frame decides
//   which row is shown and whether it is lit or blank. The model also keeps its
//   own shadow, active and pending copies of the pattern.
//   With PATTERN_SCANNER_BRIGHTNESS_EN the scanner is built with DWELL=8 and
//   BLANK=0. Otherwise it uses DWELL=4 and BLANK=2.

module tb_pattern_scanner;

    localparam int ROWS = 5;
    localparam int COLS = 5;
`ifdef PATTERN_SCANNER_BRIGHTNESS_EN
    localparam int DWELL = 8;
    localparam int BLANK = 0;
`else
    localparam int DWELL = 4;
    localparam int BLANK = 2;
`endif
    localparam int P = DWELL + BLANK;   // clocks per row slot
    localparam int F = ROWS * P;        // clocks per frame

    typedef logic [ROWS-1:0][COLS-1:0] grid_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            load = 1'b0;
    logic            enable = 1'b0;
    grid_t           pattern = '0;
    logic [2:0]      brightness = 3'd7;
    logic [ROWS-1:0] row_sel;
    logic [COLS-1:0] col_drv;
    logic            frame_done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // reference model state
    bit    m_run;
    int    m_pos;
    grid_t m_sh;
    grid_t m_act;
    bit    m_pend;
    int    m_bs;
    logic [ROWS-1:0] e_row;
    logic [COLS-1:0] e_col;
    logic            e_fd;

    pattern_scanner #(
        .ROWS (ROWS),
        .COLS (COLS),
        .DWELL(DWELL),
        .BLANK(BLANK)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pattern   (pattern),
        .load      (load),
        .enable    (enable),
`ifdef PATTERN_SCANNER_BRIGHTNESS_EN
        .brightness(brightness),
`endif
        .row_sel   (row_sel),
        .col_drv   (col_drv),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: run did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_run  = 1'b0;
        m_pos  = 0;
        m_sh   = '0;
        m_act  = '0;
        m_pend = 1'b0;
        m_bs   = 0;
        e_row  = '0;
        e_col  = '0;
        e_fd   = 1'b0;
    endtask

    // Advance the model over one clock edge using the inputs the DUT samples
    task automatic model_step();
        bit    swap;
        grid_t nact;
        int    row;
        int    off;
        int    lim;
        swap = 1'b0;
        if (!m_run) begin
            swap = m_pend;
            if (enable) begin
                m_run = 1'b1;
                m_pos = 0;
            end
        end else if (!enable) begin
            m_run = 1'b0;
        end else if (m_pos == F - 1) begin
            m_pos = 0;
            swap  = m_pend;
        end else begin
            m_pos++;
        end
        nact = swap ? m_sh : m_act;
        if (load) begin
            m_sh   = pattern;
            m_pend = 1'b1;
        end else if (swap) begin
            m_pend = 1'b0;
        end
        m_act = nact;

        e_row = '0;
        e_col = '0;
        e_fd  = 1'b0;
        if (m_run) begin
            row = m_pos / P;
            off = m_pos % P;
            if (off == 0) m_bs = int'(brightness);
`ifdef PATTERN_SCANNER_BRIGHTNESS_EN
            lim = (m_bs + 1) * DWELL / 8;
`else
            lim = DWELL;
`endif
            if (off < DWELL) begin
                e_row = ROWS'(1) << row;
                if (off < lim) e_col = m_act[row];
            end
            e_fd = (m_pos == F - 1);
        end
    endtask

    task automatic tick(input bit en, input bit ld, input grid_t pat);
        enable  = en;
        load    = ld;
        pattern = pat;
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        chk("row_sel", 32'(row_sel), 32'(e_row));
        chk("col_drv", 32'(col_drv), 32'(e_col));
        chk("frame_done", 32'(frame_done), 32'(e_fd));
    endtask

    initial begin
        grid_t diag;
        grid_t full;
        grid_t rnd;
        bit    en_r;

        for (int r = 0; r < ROWS; r++) begin
            diag[r] = COLS'(1) << r;
            full[r] = '1;
        end

        // reset held
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_row", 32'(row_sel), 32'd0);
        chk("rst_col", 32'(col_drv), 32'd0);
        chk("rst_fd", 32'(frame_done), 32'd0);
        reset = 1'b0;

        // released with enable low: display stays dark
        repeat (10) tick(1'b0, 1'b0, '0);

`ifdef PATTERN_SCANNER_BRIGHTNESS_EN
        brightness = 3'd1;
`endif
        // diagonal pattern, then scan two frames
        tick(1'b0, 1'b1, diag);
        tick(1'b0, 1'b0, '0);
        repeat (2 * F) tick(1'b1, 1'b0, '0);

        // load all-ones while row 2 is being shown
        for (int k = 0; k < F && (m_pos / P) != 2; k++) tick(1'b1, 1'b0, '0);
        tick(1'b1, 1'b1, full);
        repeat (2 * F) tick(1'b1, 1'b0, '0);

        // load on the frame_done cycle
        for (int k = 0; k < F && !e_fd; k++) tick(1'b1, 1'b0, '0);
        tick(1'b1, 1'b1, diag);
        repeat (2 * F) tick(1'b1, 1'b0, '0);

        // enable dropped during row 3 dwell, then re-enabled
        for (int k = 0; k < F && !((m_pos / P) == 3 && (m_pos % P) == 1); k++)
            tick(1'b1, 1'b0, '0);
        repeat (4) tick(1'b0, 1'b0, '0);
        tick(1'b1, 1'b0, '0);
        chk("restart_row", 32'(row_sel), 32'd1);
        repeat (F) tick(1'b1, 1'b0, '0);

        // randomized load / enable / brightness
        en_r = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 149) == 0) en_r = ~en_r;
            rnd        = grid_t'($urandom);
            brightness = 3'($urandom_range(0, 7));
            tick(en_r, ($urandom_range(0, 14) == 0), rnd);
        end

        // reset mid-frame with a load pending: the pending load must be lost
        brightness = 3'd7;
        repeat (F + 3) tick(1'b1, 1'b0, '0);
        tick(1'b1, 1'b1, full);
        repeat (2) tick(1'b1, 1'b0, '0);
        reset = 1'b1;
        #1;
        chk("midrst_row", 32'(row_sel), 32'd0);
        chk("midrst_col", 32'(col_drv), 32'd0);
        chk("midrst_fd", 32'(frame_done), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) tick(1'b0, 1'b0, '0);
        repeat (2 * F) tick(1'b1, 1'b0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pattern_scanner.md
Name: pattern_scanner

Overview:
- Downstream consumer of the 5x5 guess/result pattern grid produced by updatePattern.
- Captures the packed pattern on a load strobe into a shadow buffer and swaps it into an active buffer only at frame boundaries, so frames never tear.
- Row-multiplexes the active buffer onto an LED matrix: one-hot row select, column drive per row, fixed dwell time, blanking gap between rows.

Parameters:
- ROWS, 5, number of matrix rows (pattern outer dimension).
- COLS, 5, number of matrix columns (pattern inner dimension).
- DWELL, 1000, clocks each row is lit; must be >= 1 (>= 8 and a multiple of 8 with BRIGHTNESS_EN).
- BLANK, 16, clocks of all-off between rows; 0 allowed (blank state skipped).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- pattern  in  [ROWS-1:0][COLS-1:0]  packed grid from updatePattern; pattern[r] is row r.
- load  in  1  single-cycle strobe; captures pattern into shadow buffer.
- enable  in  1  level; high = scanning, low = display off.
- row_sel  out  ROWS  one-hot active-high row drive.
- col_drv  out  COLS  active-high column drive for the selected row.
- frame_done  out  1  one-cycle pulse at end of each complete frame.

Behaviour:
- Reset (async, active-high): state IDLE, row counter 0, dwell/blank counter 0, shadow = 0, active = 0, pending = 0, row_sel = 0, col_drv = 0, frame_done = 0.
- All outputs registered; no combinational path from inputs to outputs.
- Load: on a clk edge with load=1, shadow <= pattern and pending <= 1. Back-to-back loads: last one wins.
- States: IDLE, DWELL, BLANK.
- IDLE: outputs 0. If pending, active <= shadow and pending <= 0 on the next edge. If enable=1, go to DWELL with row 0 on the next edge.
- DWELL: row_sel = 1 << row, col_drv = active[row]. Lasts exactly DWELL cycles, then BLANK (or, if BLANK=0, directly to the next row's DWELL).
- BLANK: row_sel = 0, col_drv = 0. Lasts exactly BLANK cycles, then DWELL for row+1.
- Row wrap: after row ROWS-1 completes its BLANK (or its DWELL if BLANK=0), row wraps to 0.
- frame_done: pulses 1 for one cycle on that final cycle of row ROWS-1.
- Swap at the frame boundary: on the same edge as the wrap, if pending, active <= shadow and pending <= 0.
- Simultaneous load and swap: active takes the pre-edge shadow; the new pattern goes to shadow; pending stays 1.
- enable falling: on the next edge go to IDLE. Outputs 0, counters and row cleared, no frame_done. Re-enable restarts at row 0.
- Counters: width $clog2(max(DWELL, BLANK) + 1); row counter width $clog2(ROWS). No other arithmetic.
- Reset asserted mid-frame: immediate return to reset values and the pending load is lost.

Optional Feature:
- Macro: PATTERN_SCANNER_BRIGHTNESS_EN.
- Defined:
  - Adds input port brightness [2:0].
  - Sampled at the start of each DWELL period.
  - During DWELL, col_drv = active[row] only for the first (brightness+1)*DWELL/8 cycles of that period; col_drv = 0 for the remainder.
  - row_sel stays asserted for the full DWELL.
  - brightness=7 is identical to the feature being absent.
- Undefined: no brightness port; col_drv is driven for the full DWELL.

Test Plan (ROWS=5, COLS=5, DWELL=4, BLANK=2 unless noted):
- Reset held, then released with enable=0 -> row_sel=0, col_drv=0, frame_done=0 for 10 cycles.
- load with pattern rows {5'h01,5'h02,5'h04,5'h08,5'h10}, then enable=1 -> rows 0..4 each lit 4 cycles with col_drv=01,02,04,08,10, each followed by 2 blank cycles; frame_done pulses once every 30 cycles.
- load 5'h1F in all rows mid-frame (during row 2) -> rows 2-4 still show the old data; the next frame shows 1F on all rows; no mixed frame.
- load asserted on the frame_done cycle -> the following frame shows the previous shadow; the frame after that shows the new pattern.
- enable dropped during row 3 DWELL -> outputs 0 on the next cycle, no frame_done; re-enable restarts at row_sel=5'b00001.
- BLANK=0, DWELL=8 with BRIGHTNESS_EN and brightness=1 -> each row lit for 2 of 8 cycles, no gap between rows, frame_done every 40 cycles.
